// File: rtl/demux2x4_pkg.sv
// Shared definitions for the 2-input, 4-ring-port plus local-ejection demux.
package demux2x4_pkg;

  // Control-word (flit) width shared by every flit port.
  localparam int unsigned CTRL_W = 8;

  // Destination codes. Codes 4-7 all select local ejection.
  typedef enum logic [2:0] {
    RING0 = 3'd0,
    RING1 = 3'd1,
    RING2 = 3'd2,
    RING3 = 3'd3,
    LOCAL = 3'd4
  } dest_e;

  function automatic logic is_eject(input logic [2:0] dst);
    return dst >= LOCAL;
  endfunction

  function automatic logic [1:0] ring_sel(input logic [2:0] dst);
    return dst[1:0];
  endfunction

endpackage

// File: rtl/demux2x4_ej_fifo2w1r.sv
// Ejection FIFO: up to two writes (wr0 ahead of wr1) and one read per cycle.
module ej_fifo2w1r #(
  parameter int unsigned CW       = 8,
  parameter int unsigned EJ_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr0,
  input  logic [CW-1:0]               wr0_data,
  input  logic                        wr1,
  input  logic [CW-1:0]               wr1_data,
  input  logic                        rd,
  output logic [CW-1:0]               rd_data,
  output logic                        not_empty,
  output logic [$clog2(EJ_DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(EJ_DEPTH);

  logic [CW-1:0] mem [EJ_DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [AW-1:0] wa1;
  logic [AW:0]   cnt;
  logic          do_rd;

  // Second write lands behind the first when both are active; reads ignored when empty.
  always_comb begin
    do_rd     = rd && (cnt != '0);
    wa1       = wr0 ? wp + AW'(1) : wp;
    rd_data   = mem[rp];
    not_empty = (cnt != '0);
    count     = cnt;
  end

  // Storage array, written only outside reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (wr0) mem[wp]  <= wr0_data;
      if (wr1) mem[wa1] <= wr1_data;
    end
  end

  // Pointers wrap naturally at EJ_DEPTH (power of two); occupancy tracks net change.
  always_ff @(posedge clk) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      wp  <= wp + AW'(wr0) + AW'(wr1);
      rp  <= rp + AW'(do_rd);
      cnt <= cnt + (AW+1)'(wr0) + (AW+1)'(wr1) - (AW+1)'(do_rd);
    end
  end

endmodule

// File: rtl/demux2x4.sv
// Routes two incoming flit streams onto four registered ring ports or a shared ejection FIFO.
module demux2x4
  import demux2x4_pkg::*;
#(
  parameter int unsigned CW       = CTRL_W,
  parameter int unsigned EJ_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CW-1:0] in0_ci,
  input  logic [CW-1:0] in1_ci,
  input  logic          in0_vi,
  input  logic          in1_vi,
  input  logic [2:0]    dst0,
  input  logic [2:0]    dst1,
  output logic          in0_rdy,
  output logic          in1_rdy,
  output logic [CW-1:0] port0_co,
  output logic [CW-1:0] port1_co,
  output logic [CW-1:0] port2_co,
  output logic [CW-1:0] port3_co,
  output logic          port0_vo,
  output logic          port1_vo,
  output logic          port2_vo,
  output logic          port3_vo,
  output logic [CW-1:0] portl_co,
  output logic          portl_vo,
  input  logic          portl_rdy
);

  localparam int unsigned AW = $clog2(EJ_DEPTH);

  logic [AW:0]          ej_count;
  logic [AW+1:0]        avail;
  logic                 pop;
  logic                 conflict;
  logic                 acc0;
  logic                 acc1;
  logic                 ej0;
  logic                 ej1;
  logic [3:0]           hit0;
  logic [3:0]           hit1;
  logic [3:0]           ring_vo;
  logic [3:0][CW-1:0]   ring_co;

  // Accept logic: ring ports never stall except in1 losing a same-port conflict;
  // eject accepts count a same-cycle pop as free space, with in0 claiming first.
  always_comb begin
    pop      = portl_vo && portl_rdy;
    avail    = (AW+2)'(EJ_DEPTH) - {1'b0, ej_count} + (AW+2)'(pop);
    conflict = in0_vi && !is_eject(dst0) && !is_eject(dst1) &&
               (ring_sel(dst0) == ring_sel(dst1));
    in0_rdy  = 1'b0;
    in1_rdy  = 1'b0;
    ej0      = 1'b0;
    if (!rst) begin
      in0_rdy = is_eject(dst0) ? (avail >= (AW+2)'(1)) : 1'b1;
      ej0     = in0_vi && in0_rdy && is_eject(dst0);
      in1_rdy = is_eject(dst1) ? (avail >= (AW+2)'(1) + (AW+2)'(ej0)) : !conflict;
    end
    acc0 = in0_vi && in0_rdy;
    acc1 = in1_vi && in1_rdy;
    ej1  = acc1 && is_eject(dst1);
    hit0 = '0;
    hit1 = '0;
    for (int unsigned p = 0; p < 4; p++) begin
      hit0[p] = acc0 && !is_eject(dst0) && (ring_sel(dst0) == p[1:0]);
      hit1[p] = acc1 && !is_eject(dst1) && (ring_sel(dst1) == p[1:0]);
    end
  end

  // Ring-port registers: valid pulses for one cycle, data holds its last load.
  always_ff @(posedge clk) begin
    if (rst) begin
      ring_vo <= '0;
      ring_co <= '0;
    end else begin
      for (int unsigned p = 0; p < 4; p++) begin
        ring_vo[p] <= hit0[p] || hit1[p];
        if (hit0[p])      ring_co[p] <= in0_ci;
        else if (hit1[p]) ring_co[p] <= in1_ci;
      end
    end
  end

  ej_fifo2w1r #(
    .CW       (CW),
    .EJ_DEPTH (EJ_DEPTH)
  ) u_ej_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr0       (ej0),
    .wr0_data  (in0_ci),
    .wr1       (ej1),
    .wr1_data  (in1_ci),
    .rd        (portl_rdy),
    .rd_data   (portl_co),
    .not_empty (portl_vo),
    .count     (ej_count)
  );

  // Fan out the packed ring registers onto the named ports.
  always_comb begin
    port0_co = ring_co[0];
    port1_co = ring_co[1];
    port2_co = ring_co[2];
    port3_co = ring_co[3];
    port0_vo = ring_vo[0];
    port1_vo = ring_vo[1];
    port2_vo = ring_vo[2];
    port3_vo = ring_vo[3];
  end

endmodule

// File: tb/tb_demux2x4.sv
// Directed self-checking bench for demux2x4 with ring and ejection scoreboards.
module tb_demux2x4;
  import demux2x4_pkg::*;

  localparam int unsigned CW    = CTRL_W;
  localparam int unsigned DEPTH = 4;

  logic          clk;
  logic          rst;
  logic [CW-1:0] in0_ci, in1_ci;
  logic          in0_vi, in1_vi;
  logic [2:0]    dst0, dst1;
  logic          in0_rdy, in1_rdy;
  logic [CW-1:0] port0_co, port1_co, port2_co, port3_co;
  logic          port0_vo, port1_vo, port2_vo, port3_vo;
  logic [CW-1:0] portl_co;
  logic          portl_vo;
  logic          portl_rdy;

  logic [3:0][CW-1:0] pco;
  logic [3:0]         pvo;
  assign pco = {port3_co, port2_co, port1_co, port0_co};
  assign pvo = {port3_vo, port2_vo, port1_vo, port0_vo};

  demux2x4 #(.CW(CW), .EJ_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in0_ci(in0_ci), .in1_ci(in1_ci), .in0_vi(in0_vi), .in1_vi(in1_vi),
    .dst0(dst0), .dst1(dst1), .in0_rdy(in0_rdy), .in1_rdy(in1_rdy),
    .port0_co(port0_co), .port1_co(port1_co), .port2_co(port2_co), .port3_co(port3_co),
    .port0_vo(port0_vo), .port1_vo(port1_vo), .port2_vo(port2_vo), .port3_vo(port3_vo),
    .portl_co(portl_co), .portl_vo(portl_vo), .portl_rdy(portl_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;

  typedef struct packed {
    logic [3:0]         vo;
    logic [3:0][CW-1:0] co;
  } ring_t;

  ring_t              ring_q[$];
  logic [CW-1:0]      ej_q[$];
  logic [3:0][CW-1:0] last_co = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v0, input logic [2:0] d0, input logic [CW-1:0] c0,
                       input logic v1, input logic [2:0] d1, input logic [CW-1:0] c1,
                       input logic lr);
    in0_vi = v0; dst0 = d0; in0_ci = c0;
    in1_vi = v1; dst1 = d1; in1_ci = c1;
    portl_rdy = lr;
  endtask

  // One clock: check accepts and FIFO head against the model, then the ring outputs after the edge.
  task automatic step(input string tag);
    int    avail;
    logic  pop, r0, r1, e0, t0, t1;
    ring_t e, got;
    #1;
    pop   = (ej_q.size() > 0) && portl_rdy;
    avail = int'(DEPTH) - ej_q.size() + (pop ? 1 : 0);
    r0 = 1'b0; r1 = 1'b0;
    if (!rst) begin
      r0 = dst0[2] ? (avail >= 1) : 1'b1;
      e0 = in0_vi && r0 && dst0[2];
      r1 = dst1[2] ? (avail >= 1 + (e0 ? 1 : 0))
                   : !(in0_vi && !dst0[2] && dst0[1:0] == dst1[1:0]);
    end
    chk({tag, "_rdy0"}, 32'(in0_rdy), 32'(r0));
    chk({tag, "_rdy1"}, 32'(in1_rdy), 32'(r1));
    chk({tag, "_lvo"}, 32'(portl_vo), 32'(ej_q.size() > 0));
    if (ej_q.size() > 0) chk({tag, "_lco"}, 32'(portl_co), 32'(ej_q[0]));
    t0 = in0_vi && r0;
    t1 = in1_vi && r1;
    e.vo = '0;
    e.co = last_co;
    if (rst) begin
      e.co = '0;
      ej_q.delete();
    end else begin
      if (t0 && !dst0[2]) begin e.vo[dst0[1:0]] = 1'b1; e.co[dst0[1:0]] = in0_ci; end
      if (t1 && !dst1[2]) begin e.vo[dst1[1:0]] = 1'b1; e.co[dst1[1:0]] = in1_ci; end
      if (pop) void'(ej_q.pop_front());
      if (t0 && dst0[2]) ej_q.push_back(in0_ci);
      if (t1 && dst1[2]) ej_q.push_back(in1_ci);
    end
    last_co = e.co;
    ring_q.push_back(e);
    @(posedge clk);
    #1;
    got = ring_q.pop_front();
    chk({tag, "_vo"}, 32'(pvo), 32'(got.vo));
    for (int p = 0; p < 4; p++) chk({tag, "_co"}, 32'(pco[p]), 32'(got.co[p]));
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 3'd0, '0, 0, 3'd0, '0, 0);
    @(posedge clk);
    #1;

    // Reset with traffic presented: nothing may be accepted.
    drive(1, 3'd0, 8'hAA, 1, 3'd4, 8'hBB, 1);
    step("rst0");
    chk("rst0_lvo_after", 32'(portl_vo), 32'd0);
    rst = 1'b0;
    drive(0, 3'd0, '0, 0, 3'd0, '0, 0);
    step("idle");

    // Parallel ring routing.
    drive(1, 3'd0, 8'h11, 1, 3'd3, 8'h22, 0);
    step("par");
    chk("par_p0", 32'(port0_co), 32'h11);
    chk("par_p3", 32'(port3_co), 32'h22);
    chk("par_vo", 32'(pvo), 32'b1001);

    // Ring conflict: in0 wins, in1 retried next cycle.
    drive(1, 3'd2, 8'h33, 1, 3'd2, 8'h44, 0);
    #1;
    chk("cf_rdy0_k", 32'(in0_rdy), 32'd1);
    chk("cf_rdy1_k", 32'(in1_rdy), 32'd0);
    step("cf");
    chk("cf_p2", 32'(port2_co), 32'h33);
    drive(0, 3'd0, '0, 1, 3'd2, 8'h44, 0);
    step("cf_retry");
    chk("cf_p2b", 32'(port2_co), 32'h44);
    chk("cf_vo", 32'(pvo), 32'b0100);
    drive(0, 3'd0, '0, 0, 3'd0, '0, 0);
    step("cf_idle");
    chk("cf_hold", 32'(port2_co), 32'h44);

    // Dual eject to fill.
    drive(1, 3'd4, 8'hA0, 1, 3'd7, 8'hB0, 0);
    step("ej0");
    drive(1, 3'd4, 8'hA1, 1, 3'd7, 8'hB1, 0);
    step("ej1");
    drive(1, 3'd4, 8'hC0, 1, 3'd5, 8'hC1, 0);
    #1;
    chk("full_rdy0_k", 32'(in0_rdy), 32'd0);
    chk("full_rdy1_k", 32'(in1_rdy), 32'd0);
    chk("full_head_k", 32'(portl_co), 32'hA0);
    step("full");

    // Full plus pop: exactly one write accepted, still full afterwards.
    drive(1, 3'd4, 8'hC0, 1, 3'd6, 8'hC1, 1);
    #1;
    chk("fp_rdy0_k", 32'(in0_rdy), 32'd1);
    chk("fp_rdy1_k", 32'(in1_rdy), 32'd0);
    step("fullpop");
    drive(1, 3'd4, 8'hD0, 0, 3'd0, '0, 0);
    #1;
    chk("fp_still_full_k", 32'(in0_rdy), 32'd0);
    step("fp_hold");

    // Drain in order B0, A1, B1, C0, then pop while empty.
    drive(0, 3'd0, '0, 0, 3'd0, '0, 1);
    #1;
    chk("drain_head_k", 32'(portl_co), 32'hB0);
    repeat (4) step("drain");
    chk("drain_empty_k", 32'(portl_vo), 32'd0);
    step("pop_empty");
    chk("pop_empty_k", 32'(portl_vo), 32'd0);

    // Pointer wrap: ten single ejects interleaved with pops.
    for (int i = 0; i < 10; i++) begin
      drive(1, 3'd4, CW'(8'h50 + i), 0, 3'd0, '0, (i >= 1));
      step("wrap");
    end
    drive(0, 3'd0, '0, 0, 3'd0, '0, 1);
    repeat (2) step("wrap_drain");
    chk("wrap_empty_k", 32'(portl_vo), 32'd0);

    // Reset mid-operation with three buffered flits and port1 active.
    drive(1, 3'd4, 8'h61, 0, 3'd0, '0, 0);
    step("mr_a");
    drive(1, 3'd4, 8'h62, 0, 3'd0, '0, 0);
    step("mr_b");
    drive(1, 3'd4, 8'h63, 1, 3'd1, 8'h71, 0);
    step("mr_c");
    chk("mr_p1vo_k", 32'(pvo), 32'b0010);
    rst = 1'b1;
    drive(1, 3'd4, 8'h64, 1, 3'd2, 8'h72, 1);
    step("mr_rst");
    chk("mr_vo_k", 32'(pvo), 32'd0);
    chk("mr_lvo_k", 32'(portl_vo), 32'd0);
    rst = 1'b0;
    drive(1, 3'd1, 8'h81, 1, 3'd4, 8'h82, 0);
    step("post");
    chk("post_p1_k", 32'(port1_co), 32'h81);
    drive(0, 3'd0, '0, 0, 3'd0, '0, 1);
    #1;
    chk("post_head_k", 32'(portl_co), 32'h82);
    step("post_pop");
    step("post_idle");
    chk("post_empty_k", 32'(portl_vo), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/demux2x4.md
DEMUX2X4 -- requirements
Module: demux2x4

Interface
REQ-001 Parameter CW: default is the shared control-word width from the common defines; sets the width of every flit port.
REQ-002 Parameter EJ_DEPTH: default 4; sets ejection FIFO entries; must be a power of two, minimum 2.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in0_ci, in1_ci  input  CW each  incoming flits from the two switch outputs.
REQ-006 in0_vi, in1_vi  input  1 each  flit valid.
REQ-007 dst0, dst1  input  3 each  destination codes: 0-3 select ring port 0-3; 4-7 select local ejection.
REQ-008 in0_rdy, in1_rdy  output  1 each  accept; combinational from the current inputs and state.
REQ-009 port0_co..port3_co  output  CW each  registered ring-port flits.
REQ-010 port0_vo..port3_vo  output  1 each  registered ring-port valids.
REQ-011 portl_co  output  CW  ejection FIFO head.
REQ-012 portl_vo  output  1  FIFO not empty.
REQ-013 portl_rdy  input  1  consumer pop; a pop occurs when portl_vo && portl_rdy.

Function
REQ-014 A transfer on input k occurs when ink_vi && ink_rdy in the same cycle.
REQ-015 A ring transfer to port p appears on portp_co/portp_vo exactly 1 cycle later.
REQ-016 A ring port with no transfer in a cycle drives portp_vo=0 on the next cycle; portp_co holds its last loaded value.
REQ-017 Ring conflict: when in0 and in1 are both valid and target the same ring port, in0 wins and in1_rdy=0.
REQ-018 With no conflict, in0_rdy=1 and in1_rdy=1 for ring destinations, and ring ports never apply backpressure.
REQ-019 Ejection FIFO accepts up to 2 writes and 1 read per cycle.
REQ-020 When both inputs eject in the same cycle, the FIFO writes in0 before in1.
REQ-021 in0_rdy for an eject destination is 1 iff free entries >= 1, with a same-cycle pop counting as a free entry.
REQ-022 in1_rdy for an eject destination is 1 iff free entries, including a same-cycle pop, are >= 1 + (in0 ejecting this cycle).
REQ-023 An accepted eject flit becomes visible at portl_co no earlier than the next cycle; there is no combinational input-to-portl path.
REQ-024 FIFO pointers wrap modulo EJ_DEPTH.
REQ-025 The FIFO occupancy counter is log2(EJ_DEPTH)+1 bits and never exceeds EJ_DEPTH.
REQ-026 A pop when empty has no effect.
REQ-027 Full with a simultaneous pop accepts exactly one new write.
REQ-028 ink_rdy with ink_vi=0 has no effect on state.

Reset
REQ-029 While rst=1 at a clock edge: port0..3_vo=0, port0..3_co=0, FIFO empty (portl_vo=0), pointers and count=0.
REQ-030 Reset asserted mid-operation discards all in-flight and buffered flits, and no flit accepted in the reset cycle survives.
REQ-031 During reset, in0_rdy=in1_rdy=0.

Structure
REQ-032 The control-word width and the destination code constants (RING0..RING3=0..3, LOCAL=4) reside in the shared defines/package.
REQ-033 The ejection buffer is one sub-module, ej_fifo2w1r: 2-write, 1-read, parameterised by CW and EJ_DEPTH.
REQ-034 The ring-port registers and the conflict logic live in demux2x4 itself.

Verification
REQ-035 Bench scenario, parallel ring routing: in0 dst=0 data 0x11, in1 dst=3 data 0x22, both valid -> next cycle port0 = 0x11/vo=1 and port3 = 0x22/vo=1, ports 1 and 2 vo=0.
REQ-036 Bench scenario, ring conflict: both inputs valid with dst=2 -> in0_rdy=1, in1_rdy=0, next cycle port2_co = in0 data; in1 held, then accepted the following cycle once in0 is idle.
REQ-037 Bench scenario, dual eject to fill: dst0=4 and dst1=7 for 2 cycles, portl_rdy=0 -> 4 entries held, popped order in0a, in1a, in0b, in1b; then both rdy=0 for eject destinations.
REQ-038 Bench scenario, full plus pop: FIFO full, portl_rdy=1, both inputs eject -> in0_rdy=1, in1_rdy=0, count stays 4.
REQ-039 Bench scenario, pointer wrap: 10 single ejects interleaved with pops -> output order matches input order, and count never exceeds 4.
REQ-040 Bench scenario, reset mid-operation: FIFO holding 3 entries and port1_vo=1, rst=1 for 1 cycle -> all vo=0, portl_vo=0, and subsequent traffic is unaffected.
